// File: rtl/namco_io_chip_if.sv
// CPU-side register bus for the namco_io_chip pair.
//   CS   : chip select (window decode AND VMA)
//   WE   : CPU write strobe
//   ADDR : CPU address [5:0], bit 5 is a mirror and ignored
//   DI   : CPU write data, only [3:0] is stored
//   DO   : read data {4'h0, nibble}, combinational
interface namco_io_chip_if;
   logic       CS;
   logic       WE;
   logic [5:0] ADDR;
   logic [7:0] DI;
   logic [7:0] DO;

   modport master (output CS, output WE, output ADDR, output DI, input DO);
   modport slave  (input CS, input WE, input ADDR, input DI, output DO);
endinterface

// File: rtl/namco_io_chip.sv
// Dual Namco-style custom I/O chip pair. Chip0 ($00-$0F) does coin/credit/start/stick
// handling, chip1 ($10-$1F) dumps the DIP switches. Both run once per VBLANK.
// Ports:
//   CLKCPUx2   : CPU-domain clock, all state on posedge
//   nRESET     : asynchronous active-low reset
//   IO_RUN     : 1 = chip released, 0 = hold processing and clear credit state
//   VBLANK     : vertical blank, asynchronous, synchronised internally
//   bus        : CPU register bus (CS, WE, ADDR, DI in; DO out)
//   STICKS     : {P2 B2,B1,L,D,R,U, P1 B2,B1,L,D,R,U}, active high
//   BTNS       : {Coin, Start2, Start1}, active high
//   DSW        : {DSW2, DSW1, DSW0}, active high
//   COIN_PULSE : one-cycle pulse per accepted coin
module namco_io_chip #(
   parameter logic [7:0] MAX_CREDIT      = 8'h99,
   parameter int         COIN_PER_CREDIT = 1
) (
   input  logic                  CLKCPUx2,
   input  logic                  nRESET,
   input  logic                  IO_RUN,
   input  logic                  VBLANK,
   namco_io_chip_if.slave        bus,
   input  logic [11:0]           STICKS,
   input  logic [2:0]            BTNS,
   input  logic [23:0]           DSW,
   output logic                  COIN_PULSE
);

   localparam logic [2:0] CPC = 3'(COIN_PER_CREDIT);

   typedef enum logic [1:0] {IDLE, CHIP0, CHIP1} state_t;

   state_t     state;
   logic [3:0] regs [32];
   logic [7:0] credit;
   logic [2:0] coin_acc;
   logic       prev_coin;
   logic [1:0] prev_starts;
   logic       vb_sync1, vb_sync2, vb_prev;
   logic       vb_rise;

   logic       coin_edge, s1_edge, s2_edge;
   logic [2:0] acc_inc;
   logic [7:0] credit_c;
   logic [2:0] acc_c;
   logic       pulse_c, s1_acc, s2_acc;

   logic       unused_bits;
   assign unused_bits = ^{bus.ADDR[5], bus.DI[7:4]};

   // BCD increment that holds at MAX_CREDIT
   function automatic logic [7:0] bcd_inc_sat(input logic [7:0] x);
      if (x >= MAX_CREDIT)    return x;
      else if (x[3:0] == 4'd9) return {x[7:4] + 4'd1, 4'd0};
      else                    return {x[7:4], x[3:0] + 4'd1};
   endfunction

   // BCD subtract of 1 or 2; caller guarantees x >= n
   function automatic logic [7:0] bcd_sub(input logic [7:0] x, input logic [1:0] n);
      if (x[3:0] >= {2'b00, n}) return {x[7:4], x[3:0] - {2'b00, n}};
      else                      return {x[7:4] - 4'd1, x[3:0] + 4'd10 - {2'b00, n}};
   endfunction

   assign vb_rise = vb_sync2 & ~vb_prev;
   assign bus.DO  = {4'h0, regs[bus.ADDR[4:0]]};

   // Chip0 credit-mode frame result: coin first, then start (Start1 over Start2)
   always_comb begin
      coin_edge = BTNS[2] & ~prev_coin;
      s1_edge   = BTNS[0] & ~prev_starts[0];
      s2_edge   = BTNS[1] & ~prev_starts[1];
      acc_inc   = coin_acc + 3'd1;
      credit_c  = credit;
      acc_c     = coin_acc;
      pulse_c   = 1'b0;
      s1_acc    = 1'b0;
      s2_acc    = 1'b0;
      if (coin_edge) begin
         if (acc_inc >= CPC) begin
            acc_c    = 3'd0;
            pulse_c  = 1'b1;
            credit_c = bcd_inc_sat(credit);
         end else begin
            acc_c = acc_inc;
         end
      end
      if (s1_edge && credit_c >= 8'h01) begin
         s1_acc   = 1'b1;
         credit_c = bcd_sub(credit_c, 2'd1);
      end else if (s2_edge && credit_c >= 8'h02) begin
         s2_acc   = 1'b1;
         credit_c = bcd_sub(credit_c, 2'd2);
      end
   end

   // Control: VBLANK sync, frame FSM, credit state, coin pulse
   always_ff @(posedge CLKCPUx2 or negedge nRESET) begin
      if (!nRESET) begin
         vb_sync1    <= 1'b0;
         vb_sync2    <= 1'b0;
         vb_prev     <= 1'b0;
         state       <= IDLE;
         credit      <= 8'h00;
         coin_acc    <= 3'd0;
         prev_coin   <= 1'b0;
         prev_starts <= 2'b00;
         COIN_PULSE  <= 1'b0;
      end else begin
         vb_sync1   <= VBLANK;
         vb_sync2   <= vb_sync1;
         vb_prev    <= vb_sync2;
         COIN_PULSE <= 1'b0;
         if (!IO_RUN) begin
            state       <= IDLE;
            credit      <= 8'h00;
            coin_acc    <= 3'd0;
            prev_coin   <= 1'b0;
            prev_starts <= 2'b00;
         end else begin
            case (state)
               IDLE:  if (vb_rise) state <= CHIP0;
               CHIP0: begin
                  prev_coin   <= BTNS[2];
                  prev_starts <= BTNS[1:0];
                  if (regs[8] == 4'd1) begin
                     credit     <= credit_c;
                     coin_acc   <= acc_c;
                     COIN_PULSE <= pulse_c;
                  end
                  state <= CHIP1;
               end
               CHIP1:   state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Register file: FSM writes first so a same-cycle CPU write overrides them
   always_ff @(posedge CLKCPUx2 or negedge nRESET) begin
      if (!nRESET) begin
         for (int i = 0; i < 32; i++) regs[5'(i)] <= 4'h0;
      end else begin
         if (IO_RUN && state == CHIP0) begin
            if (regs[8] == 4'd1) begin
               regs[2] <= credit_c[7:4];
               regs[3] <= credit_c[3:0];
               regs[4] <= STICKS[3:0];
               regs[5] <= {STICKS[5], STICKS[4], s1_acc, s2_acc};
               regs[6] <= STICKS[9:6];
               regs[7] <= {STICKS[11], STICKS[10], 2'b00};
            end else if (regs[8] == 4'd3) begin
               regs[0] <= {1'b0, BTNS};
               regs[1] <= STICKS[3:0];
               regs[2] <= STICKS[9:6];
               regs[3] <= {STICKS[11], STICKS[10], STICKS[5], STICKS[4]};
            end
         end
         if (IO_RUN && state == CHIP1 && regs[24] != 4'd0) begin
            for (int n = 0; n < 6; n++) regs[5'(16 + n)] <= DSW[4*n +: 4];
         end
         if (bus.CS && bus.WE) regs[bus.ADDR[4:0]] <= bus.DI[3:0];
      end
   end

endmodule

// File: tb/tb_namco_io_chip.sv
module tb_namco_io_chip;
   localparam int CPC = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        io_run = 1'b0;
   logic        vblank = 1'b0;
   logic [11:0] sticks = '0;
   logic [2:0]  btns = '0;
   logic [23:0] dsw = '0;
   logic        coin_pulse;

   namco_io_chip_if bus();

   namco_io_chip #(.MAX_CREDIT(8'h99), .COIN_PER_CREDIT(CPC)) dut (
      .CLKCPUx2(clk), .nRESET(rst_n), .IO_RUN(io_run), .VBLANK(vblank),
      .bus(bus), .STICKS(sticks), .BTNS(btns), .DSW(dsw), .COIN_PULSE(coin_pulse)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int pulse_cnt = 0;

   always @(negedge clk) if (coin_pulse === 1'b1) pulse_cnt++;

   // Reference model: decimal credit, coin count, previous buttons, expected register file
   logic [3:0] exp_regs [32];
   int m_credit, m_acc, m_pulses;
   bit m_pc, m_ps1, m_ps2;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) exp_regs[i] = 4'h0;
      m_credit = 0; m_acc = 0; m_pc = 0; m_ps1 = 0; m_ps2 = 0;
   endfunction

   function automatic void model_frame();
      bit ce, s1e, s2e, s1a, s2a;
      if (!io_run) begin
         m_credit = 0; m_acc = 0; m_pc = 0; m_ps1 = 0; m_ps2 = 0;
         return;
      end
      ce  = btns[2] && !m_pc;
      s1e = btns[0] && !m_ps1;
      s2e = btns[1] && !m_ps2;
      s1a = 0;
      s2a = 0;
      if (exp_regs[8] == 4'd1) begin
         if (ce) begin
            m_acc++;
            if (m_acc >= CPC) begin
               m_acc = 0;
               m_pulses++;
               if (m_credit < 99) m_credit++;
            end
         end
         if (s1e && m_credit >= 1) begin
            m_credit -= 1; s1a = 1;
         end else if (s2e && m_credit >= 2) begin
            m_credit -= 2; s2a = 1;
         end
         exp_regs[2] = 4'(m_credit / 10);
         exp_regs[3] = 4'(m_credit % 10);
         exp_regs[4] = sticks[3:0];
         exp_regs[5] = {sticks[5], sticks[4], s1a, s2a};
         exp_regs[6] = sticks[9:6];
         exp_regs[7] = {sticks[11], sticks[10], 2'b00};
      end else if (exp_regs[8] == 4'd3) begin
         exp_regs[0] = {1'b0, btns};
         exp_regs[1] = sticks[3:0];
         exp_regs[2] = sticks[9:6];
         exp_regs[3] = {sticks[11], sticks[10], sticks[5], sticks[4]};
      end
      m_pc = btns[2]; m_ps1 = btns[0]; m_ps2 = btns[1];
      if (exp_regs[24] != 4'd0)
         for (int n = 0; n < 6; n++) exp_regs[16 + n] = dsw[4*n +: 4];
   endfunction

   task automatic cpu_wr(input logic [5:0] a, input logic [7:0] d);
      bus.CS = 1'b1; bus.WE = 1'b1; bus.ADDR = a; bus.DI = d;
      tick();
      bus.CS = 1'b0; bus.WE = 1'b0;
      exp_regs[a[4:0]] = d[3:0];
   endtask

   task automatic check_all(input string tag);
      logic [5:0] a;
      for (int i = 0; i < 32; i++) begin
         a = {1'($urandom % 2), 5'(i)};
         bus.ADDR = a;
         #1;
         chk($sformatf("%s reg%02h", tag, i), bus.DO, {4'h0, exp_regs[i]});
      end
      chk({tag, " pulses"}, pulse_cnt, m_pulses);
   endtask

   task automatic read_reg(input int r, output logic [7:0] v);
      bus.ADDR = 6'(r);
      #1;
      v = bus.DO;
   endtask

   // One VBLANK frame; optional latency probe and a CPU write on the chip0 cycle
   task automatic run_frame(input string tag, input int lat_reg, input int lat_edges,
                            input bit collide);
      logic [3:0] old_v, new_v;
      logic [7:0] rd;
      old_v = (lat_reg >= 0) ? exp_regs[lat_reg] : 4'h0;
      model_frame();
      if (collide) exp_regs[3] = 4'd7;
      new_v = (lat_reg >= 0) ? exp_regs[lat_reg] : 4'h0;
      vblank = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         if (collide && e == 4) begin
            bus.CS = 1'b1; bus.WE = 1'b1; bus.ADDR = 6'h03; bus.DI = 8'h07;
         end
         tick();
         if (collide && e == 4) begin
            bus.CS = 1'b0; bus.WE = 1'b0;
         end
         if (lat_reg >= 0 && e == lat_edges - 1) begin
            read_reg(lat_reg, rd);
            chk({tag, " before latency"}, rd, {4'h0, old_v});
         end
         if (lat_reg >= 0 && e == lat_edges) begin
            read_reg(lat_reg, rd);
            chk({tag, " at latency"}, rd, {4'h0, new_v});
         end
      end
      vblank = 1'b0;
      repeat (4) tick();
      check_all(tag);
   endtask

   initial begin
      bus.CS = 1'b0; bus.WE = 1'b0; bus.ADDR = '0; bus.DI = '0;
      model_reset();
      m_pulses = 0;
      repeat (3) tick();
      check_all("reset");
      chk("reset pulse", coin_pulse, 1'b0);
      rst_n = 1'b1;
      tick();

      // Mirror write: $25 aliases $05, upper data nibble dropped
      cpu_wr(6'h25, 8'h3A);
      bus.ADDR = 6'h05;
      #1;
      chk("mirror", bus.DO, 8'h0A);

      // Credit mode, coin held for three frames
      cpu_wr(6'h08, 8'h01);
      io_run = 1'b1;
      tick();
      btns = 3'b100;
      run_frame("coin1", 3, 4, 1'b0);
      run_frame("coin2", -1, 0, 1'b0);
      run_frame("coin3", -1, 0, 1'b0);
      chk("credit after coin", m_credit, 1);

      // Start2 with credit 1 is ignored, Start1 spends it
      btns = 3'b010; run_frame("start2", -1, 0, 1'b0);
      btns = 3'b000; run_frame("release", -1, 0, 1'b0);
      btns = 3'b001; run_frame("start1", 5, 4, 1'b0);
      btns = 3'b000; run_frame("release2", -1, 0, 1'b0);

      // Build credit 5, then hold with IO_RUN low
      for (int k = 0; k < 5; k++) begin
         btns = 3'b100; run_frame("c5 on", -1, 0, 1'b0);
         btns = 3'b000; run_frame("c5 off", -1, 0, 1'b0);
      end
      io_run = 1'b0;
      btns = 3'b100;
      run_frame("halted", -1, 0, 1'b0);
      btns = 3'b000;
      io_run = 1'b1;
      tick();
      run_frame("resumed", 3, 4, 1'b0);

      // Saturation at 99
      for (int k = 0; k < 102; k++) begin
         btns = 3'b100; run_frame("sat on", -1, 0, 1'b0);
         btns = 3'b000; run_frame("sat off", -1, 0, 1'b0);
      end
      chk("credit saturated", m_credit, 99);

      // Chip1 DIP dump
      cpu_wr(6'h18, 8'h01);
      dsw = 24'hA5C3F0;
      run_frame("dsw", 17, 5, 1'b0);

      // CPU write on the chip0 cycle wins
      btns = 3'b100;
      run_frame("collide", -1, 0, 1'b1);
      btns = 3'b000;

      // Randomised frames across modes and IO_RUN
      for (int k = 0; k < 150; k++) begin
         int r;
         r = int'($urandom % 8);
         if (k % 10 == 0) cpu_wr(6'h08, (r < 6) ? 8'h01 : (r == 6 ? 8'h03 : 8'($urandom % 16)));
         if (k % 13 == 0) cpu_wr(6'h18, 8'($urandom % 3));
         if ($urandom % 6 == 0) cpu_wr(6'($urandom % 64), 8'($urandom));
         io_run = ($urandom % 12) != 0;
         btns   = 3'($urandom);
         sticks = 12'($urandom);
         dsw    = 24'($urandom);
         tick();
         run_frame("rand", -1, 0, 1'b0);
      end

      // Asynchronous reset in the middle of a frame
      io_run = 1'b1;
      cpu_wr(6'h08, 8'h01);
      btns = 3'b000;
      tick();
      btns = 3'b100;
      vblank = 1'b1;
      repeat (3) tick();
      #2;
      rst_n = 1'b0;
      vblank = 1'b0;
      #1;
      model_reset();
      bus.ADDR = 6'h08;
      #1;
      chk("async reset reg08", bus.DO, 8'h00);
      chk("async reset pulse", coin_pulse, 1'b0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (4) tick();
      check_all("post reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/namco_io_chip.md
Name: namco_io_chip

Overview:
- Dual Namco-style custom I/O chip pair (chip0 at offsets $00-$0F, chip1 at $10-$1F) behind the main CPU $4800-$4FFF window.
- Presents a 32-nibble register file to the CPU and executes a per-frame update on VBLANK.
- Chip0 handles coin, credit, start and stick processing; chip1 handles the DIP switch dump.
- Its read data feeds the main CPU data-in mux.

Parameters:
- MAX_CREDIT, 8'h99, BCD credit saturation value.
- COIN_PER_CREDIT, 1, coins required per credit; legal range 1-4.

Ports:
- CLKCPUx2  in  1  CPU-domain clock; all state on posedge.
- nRESET  in  1  asynchronous active-low reset.
- IO_RUN  in  1  1 = chip released from its reset register; 0 = hold processing.
- VBLANK  in  1  video vertical blank, asynchronous to CLKCPUx2.
- CS  in  1  chip select (window decode AND VMA).
- WE  in  1  CPU write strobe.
- ADDR  in  6  CPU address [5:0]; ADDR[5] ignored (mirror).
- DI  in  8  CPU write data; only [3:0] stored.
- DO  out  8  read data {4'h0, reg[ADDR[4:0]]}; combinational, independent of CS.
- STICKS  in  12  {P2 B2,B1,L,D,R,U, P1 B2,B1,L,D,R,U}, active high.
- BTNS  in  3  {Coin, Start2, Start1}, active high.
- DSW  in  24  {DSW2, DSW1, DSW0}, active high.
- COIN_PULSE  out  1  one-cycle pulse per accepted coin (coin meter).

Behaviour:
- Reset (nRESET=0, async): all 32 regs=0, credit=8'h00, coin_acc=0, edge history=0, VBLANK sync=0, FSM=IDLE, COIN_PULSE=0.
- CPU write: CS&WE → reg[ADDR[4:0]] <= DI[3:0] at next posedge. Mode registers: chip0 = reg[$08], chip1 = reg[$18].
- VBLANK is synchronised with 2 flops; a rising edge of the synced signal while IO_RUN=1 starts the update.
- FSM: IDLE → CHIP0 (1 cycle) → CHIP1 (1 cycle) → IDLE.
  - A VBLANK edge seen while not in IDLE is dropped.
  - IO_RUN falling mid-sequence → IDLE on the next cycle; a CHIP1 write not yet done is skipped.
- CHIP0 state, mode reg[$08]=1 (credit mode):
  - Coin edge = Coin & ~prev_coin. On each edge, coin_acc += 1. When coin_acc reaches COIN_PER_CREDIT: coin_acc=0, credit = BCD+1 saturating at MAX_CREDIT, COIN_PULSE=1 for that cycle.
  - A coin edge at saturation still pulses COIN_PULSE; credit is unchanged.
  - Start1 edge with credit>=1 → credit -= 1 (BCD).
  - Start2 edge with credit>=2 → credit -= 2. With less credit the start edge is ignored.
  - Start1 takes priority over Start2 in the same frame. Coin is applied before start in the same frame.
  - Writes: reg[$02]=credit tens, reg[$03]=credit ones, reg[$04]=P1 {L,D,R,U}, reg[$05]={P1 B2, P1 B1, Start1 edge accepted, Start2 edge accepted}, reg[$06]=P2 {L,D,R,U}, reg[$07]={P2 B2, P2 B1, 0, 0}.
- CHIP0 state, mode reg[$08]=3 (raw/test):
  - reg[$00]={0, Coin, Start2, Start1}, reg[$01]=P1 dir, reg[$02]=P2 dir, reg[$03]={P2 B2, P2 B1, P1 B2, P1 B1}.
  - Credit is unchanged.
- CHIP0 state, any other mode: no register writes. Edge history still updates.
- prev_coin and prev_starts are sampled in the CHIP0 state every frame, regardless of mode.
- CHIP1 state, reg[$18]!=0: reg[$10+n] <= DSW[4n+3:4n] for n=0..5 (regs $10-$15). Mode 0 → no writes.
- IO_RUN=0:
  - credit, coin_acc and edge history clear synchronously.
  - Register file retains its contents; CPU writes are still accepted.
- Collision: a CPU write and an FSM write to the same register in the same cycle → the CPU value wins.
- Latency: VBLANK pin rise → chip0 regs valid 4 CLKCPUx2 edges later; chip1 regs 5 edges later.
- All BCD arithmetic keeps nibbles 0-9. 8'h09+1 = 8'h10.

Test Plan:
- Reset then read every address → DO=8'h00. Write $0A to $25, read $05 → 8'h0A (mirror; upper nibble dropped).
- Mode $08=1, IO_RUN=1, Coin held across 3 VBLANKs → credit 1, reg[$02]=0, reg[$03]=1, exactly one COIN_PULSE.
- Credit 8'h99 then coin edge → credit stays 99, COIN_PULSE still 1 cycle. From credit 1: Start2 edge → ignored; Start1 edge → credit 0, reg[$05][1]=1.
- Mode $18=1, DSW=24'hA5C3F0 → after VBLANK, regs $10..$15 = 0,F,3,C,5,A.
- IO_RUN=0 with credit 5, then VBLANK → no register updates. IO_RUN=1 → next frame reports credit 0.
- CPU writes reg[$03]=7 on the exact CHIP0 cycle → reg[$03]=7. nRESET asserted mid-FSM → all state zero asynchronously.
